// File: rtl/mbt_fb_writer_pkg.sv
// Shared definitions for the Mandelbrot frame-buffer writer and the display-side address decoder.
package mbt_fb_writer_pkg;

  localparam int unsigned H_RES_DEF = 800;
  localparam int unsigned V_RES_DEF = 600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } fb_state_e;

  // Four 8-bit pixels share one BRAM word, so a partial last word rounds up.
  function automatic int unsigned fb_words(input int unsigned pixels);
    return (pixels + 32'd3) / 32'd4;
  endfunction

  // Byte-enable bit for a single lane.
  function automatic logic [3:0] lane_bit(input logic [1:0] lane);
    logic [3:0] m;
    case (lane)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0010;
      2'd2:    m = 4'b0100;
      default: m = 4'b1000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mbt_lane_packer.sv
// Collects up to four raster pixels into one 32-bit word; lane k holds pixel 4w+k.
module mbt_lane_packer
  import mbt_fb_writer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        last,
  input  logic [7:0]  pix,
  output logic        commit,
  output logic [3:0]  mask,
  output logic [31:0] word
);

  logic [1:0] lane_r;
  logic [7:0] pend_r [4];
  logic [3:0] fill_r;

  assign commit = load && ((lane_r == 2'd3) || last);
  assign mask   = fill_r | lane_bit(lane_r);

  // Word as it would be written if the incoming pixel completes it; unfilled lanes read as zero.
  always_comb begin
    word = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      if (fill_r[k]) begin
        word[8*k +: 8] = pend_r[k];
      end else if (k == int'(lane_r)) begin
        word[8*k +: 8] = pix;
      end else begin
        word[8*k +: 8] = 8'h00;
      end
    end
  end

  // Lane counter, pending bytes and filled-lane mask; a commit or flush starts a fresh word.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      lane_r <= 2'd0;
      fill_r <= 4'h0;
      for (int k = 0; k < 4; k++) begin
        pend_r[k] <= 8'h00;
      end
    end else if (load) begin
      if (commit) begin
        lane_r <= 2'd0;
        fill_r <= 4'h0;
      end else begin
        pend_r[lane_r] <= pix;
        fill_r         <= mask;
        lane_r         <= lane_r + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mbt_fb_writer.sv
// Frame-buffer write port driver: packs iteration bytes into BRAM words, clears the buffer,
// and flags the end of each frame.
module mbt_fb_writer
  import mbt_fb_writer_pkg::*;
#(
  parameter int unsigned H_RES       = H_RES_DEF,
  parameter int unsigned V_RES       = V_RES_DEF,
  parameter int unsigned ADDR_W      = 17,
  parameter logic [7:0]  CLEAR_VALUE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              clear_req,
  input  logic              pix_valid,
  input  logic [7:0]        pix_iter,
  output logic              pix_ready,
  output logic [3:0]        wea,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       dout,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned FB_PIXELS = H_RES * V_RES;
  localparam int unsigned FB_WORDS  = fb_words(FB_PIXELS);
  localparam int unsigned PIX_W     = (FB_PIXELS > 1) ? $clog2(FB_PIXELS) : 1;
  localparam int unsigned WC_W      = ADDR_W + 1;
  localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(FB_PIXELS - 1);
  localparam logic [PIX_W-1:0] PIX_ONE    = PIX_W'(1);
  localparam logic [WC_W-1:0]  WORDS_END  = WC_W'(FB_WORDS);
  localparam logic [WC_W-1:0]  WC_ONE     = WC_W'(1);
  localparam logic [31:0]      CLEAR_WORD = {4{CLEAR_VALUE}};

  fb_state_e         state_r;
  logic [PIX_W-1:0]  pix_cnt_r;
  logic [WC_W-1:0]   word_cnt_r;
  logic [3:0]        wea_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       dout_r;
  logic              busy_r;
  logic              frame_done_r;

  logic        accepting_s;
  logic        xfer_s;
  logic        clear_go_s;
  logic        last_s;
  logic        commit_s;
  logic [3:0]  mask_s;
  logic [31:0] word_s;

  // Ready must already be high in the first cycle after reset, so it follows the state directly.
  assign accepting_s = (state_r == ST_IDLE) || (state_r == ST_FILL);
  assign pix_ready   = accepting_s && !rst;
  assign xfer_s      = pix_valid && pix_ready;
  assign clear_go_s  = clear_req && accepting_s;
  assign last_s      = (pix_cnt_r == LAST_PIX);

  assign wea        = wea_r;
  assign addr       = addr_r;
  assign dout       = dout_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  mbt_lane_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .flush  (restart || clear_go_s),
    .load   (xfer_s && !restart && !clear_req),
    .last   (last_s),
    .pix    (pix_iter),
    .commit (commit_s),
    .mask   (mask_s),
    .word   (word_s)
  );

  // Frame FSM with word addressing; every write strobe is registered one cycle after its cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pix_cnt_r    <= '0;
      word_cnt_r   <= '0;
      wea_r        <= 4'h0;
      addr_r       <= '0;
      dout_r       <= 32'h0000_0000;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      wea_r        <= 4'h0;
      frame_done_r <= 1'b0;
      if (restart) begin
        state_r    <= ST_IDLE;
        pix_cnt_r  <= '0;
        word_cnt_r <= '0;
        busy_r     <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_FILL: begin
            if (clear_req) begin
              state_r    <= ST_CLEAR;
              busy_r     <= 1'b1;
              pix_cnt_r  <= '0;
              wea_r      <= 4'hF;
              addr_r     <= '0;
              dout_r     <= CLEAR_WORD;
              word_cnt_r <= WC_ONE;
            end else if (xfer_s) begin
              if (commit_s) begin
                wea_r      <= mask_s;
                addr_r     <= word_cnt_r[ADDR_W-1:0];
                dout_r     <= word_s;
                word_cnt_r <= word_cnt_r + WC_ONE;
              end
              if (last_s) begin
                state_r      <= ST_DONE;
                busy_r       <= 1'b0;
                frame_done_r <= 1'b1;
              end else begin
                state_r   <= ST_FILL;
                busy_r    <= 1'b1;
                pix_cnt_r <= pix_cnt_r + PIX_ONE;
              end
            end
          end
          ST_CLEAR: begin
            if (word_cnt_r == WORDS_END) begin
              state_r    <= ST_IDLE;
              busy_r     <= 1'b0;
              word_cnt_r <= '0;
            end else begin
              wea_r      <= 4'hF;
              addr_r     <= word_cnt_r[ADDR_W-1:0];
              dout_r     <= CLEAR_WORD;
              word_cnt_r <= word_cnt_r + WC_ONE;
            end
          end
          ST_DONE: begin
            state_r    <= ST_IDLE;
            pix_cnt_r  <= '0;
            word_cnt_r <= '0;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mbt_fb_writer.sv
// Self-checking bench for mbt_fb_writer on a 5x3 frame: a pixel-index model checked every
// cycle, plus hand-computed write lists for each directed scenario.
module tb_mbt_fb_writer;

  localparam int unsigned HR = 5;
  localparam int unsigned VR = 3;
  localparam int unsigned NPIX = HR * VR;
  localparam int unsigned NWORDS = (NPIX + 3) / 4;
  localparam logic [7:0] CLR = 8'h00;

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_CLEAR = 2;
  localparam int M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst, restart, clear_req, pix_valid;
  logic [7:0]  pix_iter;
  logic        pix_ready, busy, frame_done;
  logic [3:0]  wea;
  logic [16:0] addr;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  typedef struct {
    int          a;
    logic [31:0] d;
    logic [3:0]  w;
    logic        dn;
  } wr_t;
  wr_t log_q[$];

  // model state
  int          m_mode = M_IDLE;
  int          m_pix = 0;
  int          m_clr = 0;
  logic [7:0]  m_bytes [4];
  logic [3:0]  e_wea = 4'h0;
  int          e_addr = 0;
  logic [31:0] e_dout = 32'h0;
  logic        e_done = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_ad = 1'b0;

  mbt_fb_writer #(.H_RES(HR), .V_RES(VR), .ADDR_W(17), .CLEAR_VALUE(CLR)) dut (
    .clk(clk), .rst(rst), .restart(restart), .clear_req(clear_req),
    .pix_valid(pix_valid), .pix_iter(pix_iter), .pix_ready(pix_ready),
    .wea(wea), .addr(addr), .dout(dout), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input int a, input logic [31:0] d,
                         input logic [3:0] w, input logic dn);
    checks++;
    if (idx >= log_q.size()) begin
      errors++;
      $display("FAIL %s: write %0d missing, expected addr %0d data %h wea %b", name, idx, a, d, w);
    end else if (log_q[idx].a != a || log_q[idx].d !== d || log_q[idx].w !== w || log_q[idx].dn !== dn) begin
      errors++;
      $display("FAIL %s: got addr %0d data %h wea %b done %b, expected addr %0d data %h wea %b done %b",
               name, log_q[idx].a, log_q[idx].d, log_q[idx].w, log_q[idx].dn, a, d, w, dn);
    end
  endtask

  // Frame-level model: pixel index decides lane and word; clear walks word addresses.
  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_pix = 0; m_clr = 0;
      e_wea = 4'h0; e_done = 1'b0; e_busy = 1'b0; e_addr = 0; e_dout = 32'h0; e_ad = 1'b1;
    end else begin
      e_wea = 4'h0; e_done = 1'b0;
      if (restart) begin
        m_mode = M_IDLE; m_pix = 0;
      end else if (m_mode == M_CLEAR) begin
        if (m_clr < int'(NWORDS)) begin
          e_wea = 4'hF; e_addr = m_clr; e_dout = {4{CLR}}; m_clr++;
        end else begin
          m_mode = M_IDLE;
        end
      end else if (m_mode == M_DONE) begin
        m_mode = M_IDLE; m_pix = 0;
      end else if (clear_req) begin
        m_mode = M_CLEAR; m_pix = 0; m_clr = 1;
        e_wea = 4'hF; e_addr = 0; e_dout = {4{CLR}};
      end else if (pix_valid) begin
        m_bytes[m_pix % 4] = pix_iter;
        if ((m_pix % 4) == 3 || m_pix == int'(NPIX) - 1) begin
          e_wea = 4'((1 << ((m_pix % 4) + 1)) - 1);
          e_addr = m_pix / 4;
          for (int k = 0; k < 4; k++) begin
            e_dout[8*k +: 8] = (k <= m_pix % 4) ? m_bytes[k] : 8'h00;
          end
        end
        if (m_pix == int'(NPIX) - 1) begin
          m_mode = M_DONE; e_done = 1'b1;
        end else begin
          m_mode = M_FILL; m_pix++;
        end
      end
      e_ad = (e_wea != 4'h0);
      e_busy = (m_mode == M_FILL || m_mode == M_CLEAR);
    end
  end

  // Per-cycle comparison against the model, and capture of every DUT write.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wea", 32'(wea), 32'(e_wea));
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("pix_ready", 32'(pix_ready),
          32'((!rst) && (m_mode == M_IDLE || m_mode == M_FILL)));
      if (e_ad) begin
        chk("addr", 32'(addr), 32'(e_addr));
        chk("dout", dout, e_dout);
      end
      if (wea !== 4'h0) log_q.push_back('{a: int'(addr), d: dout, w: wea, dn: frame_done});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input int gap);
    pix_valid = 1'b1; pix_iter = v;
    tick();
    pix_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    int nb;
    rst = 1'b1; restart = 1'b0; clear_req = 1'b0; pix_valid = 1'b0; pix_iter = 8'h00;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(pix_ready), 32'd1);
    tick();

    // back-to-back pixels
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    tick();
    chk("b2b_count", 32'(log_q.size()), 32'd2);
    chk_log("b2b_w0", 0, 0, 32'h04030201, 4'hF, 1'b0);
    chk_log("b2b_w1", 1, 1, 32'h08070605, 4'hF, 1'b0);
    log_q.delete();
    pulse_restart();

    // valid toggling
    for (int i = 1; i <= 8; i++) send(8'(i), 1);
    tick();
    chk("gap_count", 32'(log_q.size()), 32'd2);
    chk_log("gap_w0", 0, 0, 32'h04030201, 4'hF, 1'b0);
    chk_log("gap_w1", 1, 1, 32'h08070605, 4'hF, 1'b0);
    log_q.delete();
    pulse_restart();

    // full 15-pixel frame
    for (int i = 0; i < 15; i++) send(8'(8'h10 + i), 0);
    tick();
    @(negedge clk);
    chk("frame_end_ready", 32'(pix_ready), 32'd1);
    chk("frame_end_busy", 32'(busy), 32'd0);
    chk("frame_count", 32'(log_q.size()), 32'd4);
    chk_log("frame_w0", 0, 0, 32'h13121110, 4'hF, 1'b0);
    chk_log("frame_w1", 1, 1, 32'h17161514, 4'hF, 1'b0);
    chk_log("frame_w2", 2, 2, 32'h1B1A1918, 4'hF, 1'b0);
    chk_log("frame_w3", 3, 3, 32'h001E1D1C, 4'b0111, 1'b1);
    log_q.delete();
    tick();

    // clear from IDLE
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("clear_busy_cycles", 32'(nb), 32'd4);
    chk("clear_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_log("clear_w", i, i, 32'h0, 4'hF, 1'b0);
    log_q.delete();
    tick();

    // restart with a concurrent pixel after 6 accepted
    for (int i = 1; i <= 6; i++) send(8'(8'h20 + i), 0);
    restart = 1'b1; pix_valid = 1'b1; pix_iter = 8'h27;
    tick();
    restart = 1'b0; pix_valid = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(8'h30 + i), 0);
    tick();
    chk("restart_count", 32'(log_q.size()), 32'd2);
    chk_log("restart_w0", 0, 0, 32'h24232221, 4'hF, 1'b0);
    chk_log("restart_w1", 1, 0, 32'h34333231, 4'hF, 1'b0);
    log_q.delete();
    pulse_restart();

    // clear during FILL with a concurrent pixel; a second clear_req mid-clear is ignored
    send(8'h41, 0);
    send(8'h42, 0);
    clear_req = 1'b1; pix_valid = 1'b1; pix_iter = 8'h43;
    tick();
    clear_req = 1'b0; pix_valid = 1'b0;
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (5) tick();
    chk("fillclr_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_log("fillclr_w", i, i, 32'h0, 4'hF, 1'b0);
    log_q.delete();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
